// File: rtl/axis_mask_fields_icrc_mp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_mask_fields_icrc_mp_pkg                                             |
// | RoCEv2 ICRC variant-field offsets and the per-byte mask function.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package axis_mask_fields_icrc_mp_pkg;

    // Byte offsets relative to the start of the IP header.
    localparam int IP4_TOS      = 1;
    localparam int IP4_TTL      = 8;
    localparam int IP4_CSUM     = 10;
    localparam int UDP4_CSUM    = 26;
    localparam int BTH4_RESV    = 32;
    localparam int IP6_TC_HI    = 0;
    localparam int IP6_TC_LO    = 1;
    localparam int IP6_FLOW_END = 3;
    localparam int IP6_HOP      = 7;
    localparam int UDP6_CSUM    = 46;
    localparam int BTH6_RESV    = 52;
    localparam int MASK_SPAN    = BTH6_RESV + 1;

    typedef enum logic {
        MODE_IPV4 = 1'b0,
        MODE_IPV6 = 1'b1
    } ip_mode_e;

    // OR-mask for the byte at relative offset r (r may be negative inside L2).
    function automatic logic [7:0] lane_mask(input int r, input ip_mode_e mode);
        logic [7:0] m;
        m = 8'h00;
        if (mode == MODE_IPV6) begin
            if (r == IP6_TC_HI)
                m = 8'h0F;
            else if ((r >= IP6_TC_LO && r <= IP6_FLOW_END) || r == IP6_HOP ||
                     r == UDP6_CSUM || r == UDP6_CSUM + 1 || r == BTH6_RESV)
                m = 8'hFF;
        end else begin
            if (r == IP4_TOS || r == IP4_TTL || r == IP4_CSUM || r == IP4_CSUM + 1 ||
                r == UDP4_CSUM || r == UDP4_CSUM + 1 || r == BTH4_RESV)
                m = 8'hFF;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_mask_fields_icrc_mp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_mask_fields_icrc_mp_if                                              |
// | AXI-Stream bundle with source (master) and sink (slave) views.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface axis_mask_fields_icrc_mp_if #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_mask_fields_icrc_mp_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_mask_fields_icrc_mp_skid                                            |
// | Full-throughput register slice: output reg + temp reg, registered ready. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axis_mask_fields_icrc_mp_skid #(
    parameter int WIDTH = 8
) (
    input  wire              clk,
    input  wire              rst,
    input  wire [WIDTH-1:0]  in_data,
    input  wire              in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  wire              out_ready
);
    logic [WIDTH-1:0] tmp_data;
    logic             tmp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            tmp_valid <= 1'b0;
            out_data  <= '0;
            tmp_data  <= '0;
        end else begin
            // Ready only when the temp slot is guaranteed free next cycle.
            in_ready <= out_ready || (!out_valid && !tmp_valid);
            if (in_ready) begin
                if (out_ready || !out_valid) begin
                    out_data  <= in_data;
                    out_valid <= in_valid;
                end else begin
                    tmp_data  <= in_data;
                    tmp_valid <= in_valid;
                end
            end else if (out_ready) begin
                out_data  <= tmp_data;
                out_valid <= tmp_valid;
                tmp_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/axis_mask_fields_icrc_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_mask_fields_icrc_mp                                                 |
// | Sets ICRC-variant header bytes to ones; emits masked + original data.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axis_mask_fields_icrc_mp
    import axis_mask_fields_icrc_mp_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int HDR_OFFSET = 0,
    parameter int OUT_REG    = 1
) (
    input  wire                   clk,
    input  wire                   rst,
    axis_mask_fields_icrc_mp_if.slave  s_axis,
    input  wire                   s_axis_ipv6,
    axis_mask_fields_icrc_mp_if.master m_axis,
    output logic [DATA_WIDTH-1:0] m_axis_not_masked_tdata
);
    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int NBEATS  = (HDR_OFFSET + MASK_SPAN + BYTES - 1) / BYTES;
    localparam int CNT_W   = $clog2(NBEATS + 1);
    localparam int KEEP_LSB = 1;
    localparam int MSK_LSB  = KEEP_LSB + BYTES;
    localparam int RAW_LSB  = MSK_LSB + DATA_WIDTH;
    localparam int USR_LSB  = RAW_LSB + DATA_WIDTH;
    localparam int PKT_W    = USR_LSB + USER_WIDTH;

    logic [CNT_W-1:0]      beat_cnt;
    ip_mode_e              mode_q;
    ip_mode_e              mode_cur;
    logic                  accept;
    logic [DATA_WIDTH-1:0] masked;
    logic [PKT_W-1:0]      in_pkt;
    logic [PKT_W-1:0]      st1_data;
    logic                  st1_valid;
    logic                  st1_ready;
    logic [PKT_W-1:0]      out_pkt;
    logic                  out_valid;

    assign accept   = s_axis.tvalid && s_axis.tready;
    // The first beat uses the live mode input; later beats the latched one.
    assign mode_cur = (beat_cnt == '0) ? ip_mode_e'(s_axis_ipv6) : mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            mode_q   <= MODE_IPV4;
        end else if (accept) begin
            if (beat_cnt == '0)
                mode_q <= ip_mode_e'(s_axis_ipv6);
            if (s_axis.tlast)
                beat_cnt <= '0;
            else if (beat_cnt != CNT_W'(NBEATS))
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < BYTES; i++) begin : g_lane
            assign masked[8*i +: 8] = s_axis.tdata[8*i +: 8] |
                lane_mask(int'(beat_cnt) * BYTES + i - HDR_OFFSET, mode_cur);
        end
    endgenerate

    assign in_pkt = {s_axis.tuser, s_axis.tdata, masked, s_axis.tkeep, s_axis.tlast};

    axis_mask_fields_icrc_mp_skid #(.WIDTH(PKT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_pkt),
        .in_valid  (s_axis.tvalid),
        .in_ready  (s_axis.tready),
        .out_data  (st1_data),
        .out_valid (st1_valid),
        .out_ready (st1_ready)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            axis_mask_fields_icrc_mp_skid #(.WIDTH(PKT_W)) u_out_reg (
                .clk       (clk),
                .rst       (rst),
                .in_data   (st1_data),
                .in_valid  (st1_valid),
                .in_ready  (st1_ready),
                .out_data  (out_pkt),
                .out_valid (out_valid),
                .out_ready (m_axis.tready)
            );
        end else begin : g_no_out_reg
            assign out_pkt   = st1_data;
            assign out_valid = st1_valid;
            assign st1_ready = m_axis.tready;
        end
    endgenerate

    assign m_axis.tvalid           = out_valid;
    assign m_axis.tlast            = out_pkt[0];
    assign m_axis.tkeep            = out_pkt[MSK_LSB-1:KEEP_LSB];
    assign m_axis.tdata            = out_pkt[RAW_LSB-1:MSK_LSB];
    assign m_axis_not_masked_tdata = out_pkt[USR_LSB-1:RAW_LSB];
    assign m_axis.tuser            = out_pkt[PKT_W-1:USR_LSB];
endmodule
`default_nettype wire

// File: tb/tb_axis_mask_fields_icrc_mp.sv
`default_nettype none
// Bench for axis_mask_fields_icrc_mp: 64-bit bus, Ethernet offset, output register on.
module tb_axis_mask_fields_icrc_mp;
    localparam int DW  = 64;
    localparam int UW  = 2;
    localparam int KW  = DW / 8;
    localparam int HDR = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_mask_fields_icrc_mp_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
    axis_mask_fields_icrc_mp_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();
    logic          ipv6;
    logic [DW-1:0] raw_out;

    axis_mask_fields_icrc_mp #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .HDR_OFFSET(HDR), .OUT_REG(1)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s_axis                  (s_if),
        .s_axis_ipv6             (ipv6),
        .m_axis                  (m_if),
        .m_axis_not_masked_tdata (raw_out)
    );

    typedef struct packed {
        logic [DW-1:0] masked;
        logic [DW-1:0] raw;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    typedef struct {
        logic          v6;
        logic [DW-1:0] data;
        logic          last;
        logic [DW-1:0] exp;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[20];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int a, input logic v6, input logic [7:0] d);
        int r;
        r = a - HDR;
        if (v6) begin
            if (r == 0) return d | 8'h0F;
            if (r inside {1, 2, 3, 7, 46, 47, 52}) return 8'hFF;
        end else if (r inside {1, 8, 10, 11, 26, 27, 32}) begin
            return 8'hFF;
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] ref_beat(input int beat, input logic v6, input logic [DW-1:0] d);
        logic [DW-1:0] res;
        for (int l = 0; l < KW; l++)
            res[8*l +: 8] = ref_byte(beat * KW + l, v6, d[8*l +: 8]);
        return res;
    endfunction

    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Output side of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_beat: got output beat %h, expected none", m_if.tdata);
            end else begin
                e = exp_q.pop_front();
                check("masked_tdata", m_if.tdata, e.masked);
                check("not_masked_tdata", raw_out, e.raw);
                check("tkeep", DW'(m_if.tkeep), DW'(e.keep));
                check("tlast", DW'(m_if.tlast), DW'(e.last));
                check("tuser", DW'(m_if.tuser), DW'(e.user));
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic [UW-1:0] u, input logic v6, input logic [DW-1:0] exp_m);
        int t;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tuser  = u;
        ipv6        = v6;
        s_if.tvalid = 1'b1;
        for (t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (s_if.tready) break;
        end
        if (t == 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: tready stayed %b, required 1", s_if.tready);
        end else begin
            exp_q.push_back('{masked: exp_m, raw: d, keep: k, last: l, user: u});
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nbeats, input logic v6, input logic toggle, input logic gaps);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          last;
        logic          mode_in;
        for (int b = 0; b < nbeats; b++) begin
            d       = {$urandom, $urandom};
            last    = (b == nbeats - 1);
            k       = last ? ({KW{1'b1}} >> $urandom_range(0, KW - 1)) : {KW{1'b1}};
            mode_in = (b == 0 || !toggle) ? v6 : 1'($urandom_range(0, 1));
            send_beat(d, k, last, UW'($urandom), mode_in, ref_beat(b, v6, d));
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int c;
        for (c = 0; c < budget && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d beats still pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // IPv4 zeros packet; mode input flips after the first beat and must be ignored.
        vecs[0]  = '{1'b0, 64'h0, 1'b0, 64'h0};
        vecs[1]  = '{1'b1, 64'h0, 1'b0, 64'hFF00_0000_0000_0000};
        vecs[2]  = '{1'b1, 64'h0, 1'b0, 64'h00FF_0000_0000_0000};
        vecs[3]  = '{1'b1, 64'h0, 1'b0, 64'h0000_0000_0000_FFFF};
        vecs[4]  = '{1'b1, 64'h0, 1'b0, 64'h0};
        vecs[5]  = '{1'b1, 64'h0, 1'b0, 64'h00FF_0000_0000_FFFF};
        vecs[6]  = '{1'b1, 64'h0, 1'b1, 64'h0};
        // IPv6 A5 packet back-to-back, 10 beats to run past the saturation point.
        vecs[7]  = '{1'b1, {8{8'hA5}}, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[8]  = '{1'b0, {8{8'hA5}}, 1'b0, 64'hFFAF_A5A5_A5A5_A5A5};
        vecs[9]  = '{1'b0, {8{8'hA5}}, 1'b0, 64'hA5A5_FFA5_A5A5_FFFF};
        vecs[10] = '{1'b0, {8{8'hA5}}, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[11] = '{1'b0, {8{8'hA5}}, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[12] = '{1'b0, {8{8'hA5}}, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[13] = '{1'b0, {8{8'hA5}}, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[14] = '{1'b0, {8{8'hA5}}, 1'b0, 64'hA5A5_FFFF_A5A5_A5A5};
        vecs[15] = '{1'b0, {8{8'hA5}}, 1'b0, 64'hA5A5_A5A5_A5FF_A5A5};
        vecs[16] = '{1'b1, {8{8'hA5}}, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5};
        // Single-beat packet, then a 2-beat packet that must restart at beat 0.
        vecs[17] = '{1'b0, 64'h1122_3344_5566_7788, 1'b1, 64'h1122_3344_5566_7788};
        vecs[18] = '{1'b0, 64'h0, 1'b0, 64'h0};
        vecs[19] = '{1'b0, 64'h0, 1'b1, 64'hFF00_0000_0000_0000};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        ipv6        = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_s_tready", DW'(s_if.tready), 0);
        check("reset_m_tvalid", DW'(m_if.tvalid), 0);
        check("reset_m_tdata", m_if.tdata, 0);
        check("reset_not_masked", raw_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("tready_first_cycle", DW'(s_if.tready), 0);
        @(negedge clk);
        check("tready_rises", DW'(s_if.tready), 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++)
            send_beat(vecs[i].data, {KW{1'b1}}, vecs[i].last, UW'(i), vecs[i].v6, vecs[i].exp);
        drain(200);

        // Two-cycle latency with the output register.
        send_beat(64'h0123_4567_89AB_CDEF, {KW{1'b1}}, 1'b1, 2'd1, 1'b0, 64'h0123_4567_89AB_CDEF);
        check("latency_cycle1_tvalid", DW'(m_if.tvalid), 0);
        @(posedge clk);
        #1;
        check("latency_cycle2_tvalid", DW'(m_if.tvalid), 1);
        drain(50);

        // Random back-pressure, idle gaps and mid-packet mode toggling.
        ready_mode = 1;
        for (int p = 0; p < 200; p++)
            send_pkt($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        drain(5000);

        // Reset in the middle of a stalled packet.
        ready_mode = 2;
        @(posedge clk);
        #1;
        send_pkt(2, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midreset_m_tvalid", DW'(m_if.tvalid), 0);
        check("midreset_s_tready", DW'(s_if.tready), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        send_pkt(6, 1'b1, 1'b1, 1'b0);
        send_pkt(1, 1'b0, 1'b0, 1'b0);
        send_pkt(7, 1'b0, 1'b0, 1'b0);
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
